// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the execute-stage operand front end.
//   - ALU control group encodings (upper two bits of the 4-bit ALU control)
//   - Bit positions of the {z,v,n} flag-update mask
//   - Register-zero address (R0 always reads as zero)
package ex_operand_stage_pkg;

  typedef enum logic [1:0] {
    ALU_GRP_ADDSUB = 2'b00,  // add / sub / paddsb
    ALU_GRP_NAND   = 2'b01,
    ALU_GRP_XOR    = 2'b10,
    ALU_GRP_SHIFT  = 2'b11
  } alu_grp_e;

  localparam int FLAG_Z_BIT = 2;
  localparam int FLAG_V_BIT = 1;
  localparam int FLAG_N_BIT = 0;

  localparam int REG_ZERO = 0;

  function automatic alu_grp_e alu_grp(input logic [3:0] ctrl);
    return alu_grp_e'(ctrl[3:2]);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding priority select for one ALU source operand.
// Ports:
//   addr          latched source register address
//   data          latched register-file read data
//   exmem_*       MEM-stage producer (highest priority)
//   memwb_*       WB-stage producer
//   data_out      forwarded operand value
module ex_operand_stage_fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic          exmem_we,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_we,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] data_out
);

  always_comb begin
    data_out = data;
    // R0 is hardwired zero even if a producer claims to write it.
    if (addr == RW'(REG_ZERO)) begin
      data_out = '0;
    end else if (exmem_we && (exmem_rd == addr)) begin
      data_out = exmem_result;
    end else if (memwb_we && (memwb_rd == addr)) begin
      data_out = memwb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select with forwarding, plus the
// architectural V/N/Z flag register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold stage / insert bubble (flush wins)
//   id_*                decoded instruction fields from ID
//   exmem_*, memwb_*    downstream producers used for forwarding
//   alu_v/n/z           ALU flag outputs for the current EX operands
//   alu_a, alu_b        forwarded ALU operands (alu_b may be the immediate)
//   alu_ctrl            registered ALU control
//   ex_valid, ex_rd_addr, ex_reg_we   EX slot status and destination
//   flag_v/n/z          architectural flags
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [3:0]    id_alu_ctrl,
  input  logic [RW-1:0] id_rd_addr,
  input  logic          id_reg_we,
  input  logic [2:0]    id_flag_mask,
  input  logic          exmem_we,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_we,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  input  logic          alu_v,
  input  logic          alu_n,
  input  logic          alu_z,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_ctrl,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd_addr,
  output logic          ex_reg_we,
  output logic          flag_v,
  output logic          flag_n,
  output logic          flag_z
);

  logic          valid_q;
  logic [RW-1:0] rs_addr_q;
  logic [RW-1:0] rt_addr_q;
  logic [DW-1:0] rs_data_q;
  logic [DW-1:0] rt_data_q;
  logic [DW-1:0] imm_q;
  logic          use_imm_q;
  logic [3:0]    alu_ctrl_q;
  logic [RW-1:0] rd_addr_q;
  logic          reg_we_q;
  logic [2:0]    flag_mask_q;
  logic          flag_v_q;
  logic          flag_n_q;
  logic          flag_z_q;

  logic          wb_hit_rs;
  logic          wb_hit_rt;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  // A producer that retires while we are stalled would vanish from the
  // forwarding window, so its value is folded into the latched operand.
  assign wb_hit_rs = memwb_we && (memwb_rd == rs_addr_q) && (rs_addr_q != RW'(REG_ZERO));
  assign wb_hit_rt = memwb_we && (memwb_rd == rt_addr_q) && (rt_addr_q != RW'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_ctrl_q  <= '0;
      rd_addr_q   <= '0;
      reg_we_q    <= 1'b0;
      flag_mask_q <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_we_q    <= 1'b0;
      flag_mask_q <= '0;
    end else if (stall) begin
      if (wb_hit_rs) rs_data_q <= memwb_data;
      if (wb_hit_rt) rt_data_q <= memwb_data;
    end else begin
      valid_q     <= id_valid;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      alu_ctrl_q  <= id_alu_ctrl;
      rd_addr_q   <= id_rd_addr;
      reg_we_q    <= id_reg_we;
      flag_mask_q <= id_flag_mask;
    end
  end

  // Flags follow the instruction currently in EX, independent of what is
  // being flushed in behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_v_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else if (valid_q && !stall) begin
      if (flag_mask_q[FLAG_Z_BIT]) flag_z_q <= alu_z;
      if (flag_mask_q[FLAG_V_BIT]) flag_v_q <= alu_v;
      if (flag_mask_q[FLAG_N_BIT]) flag_n_q <= alu_n;
    end
  end

  ex_operand_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .addr         (rs_addr_q),
    .data         (rs_data_q),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_data   (memwb_data),
    .data_out     (fwd_rs)
  );

  ex_operand_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .addr         (rt_addr_q),
    .data         (rt_data_q),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_data   (memwb_data),
    .data_out     (fwd_rt)
  );

  assign alu_a      = fwd_rs;
  assign alu_b      = use_imm_q ? imm_q : fwd_rt;
  assign alu_ctrl   = alu_ctrl_q;
  assign ex_valid   = valid_q;
  assign ex_rd_addr = rd_addr_q;
  assign ex_reg_we  = valid_q & reg_we_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;
  assign flag_z     = flag_z_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          id_valid;
  logic [RW-1:0] id_rs_addr;
  logic [RW-1:0] id_rt_addr;
  logic [DW-1:0] id_rs_data;
  logic [DW-1:0] id_rt_data;
  logic [DW-1:0] id_imm;
  logic          id_use_imm;
  logic [3:0]    id_alu_ctrl;
  logic [RW-1:0] id_rd_addr;
  logic          id_reg_we;
  logic [2:0]    id_flag_mask;
  logic          exmem_we;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_we;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic          alu_v;
  logic          alu_n;
  logic          alu_z;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_ctrl;
  logic          ex_valid;
  logic [RW-1:0] ex_rd_addr;
  logic          ex_reg_we;
  logic          flag_v;
  logic          flag_n;
  logic          flag_z;

  int n_tests = 0;
  int n_fail  = 0;

  ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm       (id_imm),
    .id_use_imm   (id_use_imm),
    .id_alu_ctrl  (id_alu_ctrl),
    .id_rd_addr   (id_rd_addr),
    .id_reg_we    (id_reg_we),
    .id_flag_mask (id_flag_mask),
    .exmem_we     (exmem_we),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_we     (memwb_we),
    .memwb_rd     (memwb_rd),
    .memwb_data   (memwb_data),
    .alu_v        (alu_v),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .ex_valid     (ex_valid),
    .ex_rd_addr   (ex_rd_addr),
    .ex_reg_we    (ex_reg_we),
    .flag_v       (flag_v),
    .flag_n       (flag_n),
    .flag_z       (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_fwd;
    exmem_we = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic set_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                        input logic [DW-1:0] imm, input logic ui, input logic [3:0] ctrl,
                        input logic [RW-1:0] rd, input logic we, input logic [2:0] mask);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_use_imm = ui; id_alu_ctrl = ctrl; id_rd_addr = rd; id_reg_we = we;
    id_flag_mask = mask;
  endtask

  function automatic logic [2:0] flags_zvn();
    return {flag_z, flag_v, flag_n};
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 4'd1, 4'd2, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'hA, 4'd5, 1'b1, 3'b111);
    idle_fwd();
    alu_v = 1'b1; alu_n = 1'b1; alu_z = 1'b1;

    // reset held two cycles
    tick(); tick();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_reg_we", ex_reg_we, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_ex_rd_addr", ex_rd_addr, 0);
    check("rst_flags", flags_zvn(), 3'b000);
    rst = 1'b0;
    alu_v = 1'b0; alu_n = 1'b0; alu_z = 1'b0;

    // EX/MEM over MEM/WB forwarding
    set_id(1'b1, 4'd3, 4'd4, 16'h0001, 16'h0044, 16'h7777, 1'b0, 4'h6, 4'd7, 1'b1, 3'b000);
    tick();
    id_valid = 1'b0;
    exmem_we = 1'b1; exmem_rd = 4'd3; exmem_result = 16'h1234;
    memwb_we = 1'b1; memwb_rd = 4'd3; memwb_data = 16'hBEEF;
    #1;
    check("fwd_exmem_a", alu_a, 16'h1234);
    check("fwd_b_latched", alu_b, 16'h0044);
    check("cap_alu_ctrl", alu_ctrl, 4'h6);
    check("cap_ex_valid", ex_valid, 1);
    check("cap_rd_addr", ex_rd_addr, 7);
    check("cap_reg_we", ex_reg_we, 1);
    exmem_we = 1'b0; #1;
    check("fwd_memwb_a", alu_a, 16'hBEEF);
    memwb_we = 1'b0; #1;
    check("fwd_none_a", alu_a, 16'h0001);

    // R0 guard and immediate bypasses forwarding
    set_id(1'b1, 4'd0, 4'd2, 16'h5555, 16'h2222, 16'h8001, 1'b1, 4'hC, 4'd9, 1'b0, 3'b000);
    tick();
    exmem_we = 1'b1; exmem_rd = 4'd0; exmem_result = 16'hFFFF;
    memwb_we = 1'b1; memwb_rd = 4'd2; memwb_data = 16'hDEAD;
    #1;
    check("r0_guard_a", alu_a, 16'h0000);
    check("imm_b", alu_b, 16'h8001);
    check("we0_reg_we", ex_reg_we, 0);
    idle_fwd();

    // masked flag update: only Z
    set_id(1'b1, 4'd1, 4'd1, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 4'd1, 1'b0, 3'b100);
    tick();
    alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
    id_valid = 1'b0;
    tick();
    check("mask_z_only", flags_zvn(), 3'b100);
    alu_z = 1'b0;
    tick();
    check("bubble_no_flag", flags_zvn(), 3'b100);

    // flush has priority over stall
    set_id(1'b1, 4'd1, 4'd2, 16'h0, 16'h0, 16'h0, 1'b0, 4'h3, 4'd8, 1'b1, 3'b111);
    alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
    tick();
    check("pre_flush_valid", ex_valid, 1);
    stall = 1'b1; flush = 1'b1; id_valid = 1'b1;
    alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
    tick();
    check("flush_ex_valid", ex_valid, 0);
    check("flush_reg_we", ex_reg_we, 0);
    check("flush_flags", flags_zvn(), 3'b100);
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    tick();
    check("post_flush_flags", flags_zvn(), 3'b100);

    // stall with a retiring producer captured into latched rt
    set_id(1'b1, 4'd6, 4'd5, 16'h0066, 16'h0011, 16'h0, 1'b0, 4'h9, 4'd4, 1'b1, 3'b111);
    alu_z = 1'b0; alu_v = 1'b0; alu_n = 1'b0;
    tick();
    stall = 1'b1;
    memwb_we = 1'b1; memwb_rd = 4'd5; memwb_data = 16'h00A5;
    alu_z = 1'b1; alu_v = 1'b1; alu_n = 1'b1;
    id_rt_data = 16'h9999; id_alu_ctrl = 4'hF;
    tick();
    idle_fwd(); #1;
    check("stall_wb_capture_b", alu_b, 16'h00A5);
    check("stall_hold_a", alu_a, 16'h0066);
    check("stall_hold_ctrl", alu_ctrl, 4'h9);
    check("stall1_flags", flags_zvn(), 3'b100);
    tick();
    check("stall2_b", alu_b, 16'h00A5);
    check("stall2_flags", flags_zvn(), 3'b100);
    check("stall2_valid", ex_valid, 1);
    stall = 1'b0; #1;
    check("release_b", alu_b, 16'h00A5);
    alu_z = 1'b0; alu_v = 1'b1; alu_n = 1'b1;
    tick();
    check("release_flags", flags_zvn(), 3'b011);
    check("release_new_ctrl", alu_ctrl, 4'hF);

    // reset during stall empties the stage
    stall = 1'b1; rst = 1'b1;
    tick();
    check("rst_stall_valid", ex_valid, 0);
    check("rst_stall_flags", flags_zvn(), 3'b000);
    check("rst_stall_ctrl", alu_ctrl, 0);
    rst = 1'b0; stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
